// File: rtl/cache_pkg.sv
// Shared cache geometry: line, beat and counter sizes.
// Line and beat typedefs used by the cache/memory boundary.
package cache_pkg;

  localparam int s_offset  = 5;
  localparam int s_line    = 8 * 2**s_offset;
  localparam int s_burst   = 64;
  localparam int num_beats = s_line / s_burst;
  localparam int cnt_w     = $clog2(num_beats);

  typedef logic [s_line-1:0]  line_t;
  typedef logic [s_burst-1:0] beat_t;

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Cache-side and memory-side signals of the line adaptor.
// slave = adaptor view, master = cache/memory view.
interface cacheline_adaptor_if;
  import cache_pkg::*;

  line_t       line_i;
  line_t       line_o;
  logic [31:0] address_i;
  logic        read_i;
  logic        write_i;
  logic        resp_o;

  beat_t       burst_i;
  beat_t       burst_o;
  logic [31:0] address_o;
  logic        read_o;
  logic        write_o;
  logic        resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i,
    input  burst_i, resp_i,
    output line_o, resp_o,
    output burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i,
    output burst_i, resp_i,
    input  line_o, resp_o,
    input  burst_o, address_o, read_o, write_o
  );

endinterface

// File: rtl/cacheline_adaptor.sv
// Moves one cache line between the line-wide cache port
// and 64-bit memory bursts (4-beat fill / writeback).
module cacheline_adaptor
  import cache_pkg::*;
(
  input  logic clk,
  input  logic rst,
  cacheline_adaptor_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [cnt_w-1:0] cnt;
  logic [num_beats-1:0][s_burst-1:0] wline;
  logic [num_beats-1:0][s_burst-1:0] fill;
  logic [31:0] addr;

  logic busy;
  logic beat;
  logic last;
  logic take;

  assign busy = (state == READ) | (state == WRITE);
  assign beat = busy & bus.resp_i;
  assign last = (cnt == cnt_w'(num_beats - 1));
  assign take = (state == IDLE) & (bus.read_i | bus.write_i);

  // offset bits of the request address carry no meaning here
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.address_i[s_offset-1:0]};

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next state: writeback wins over fill when both are requested
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (bus.write_i)     state_n = WRITE;
        else if (bus.read_i) state_n = READ;
      end
      READ, WRITE: begin
        if (beat && last) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // address/line latch, beat counter and fill assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      wline <= '0;
      fill  <= '0;
      addr  <= '0;
    end else begin
      if (take)
        addr <= {bus.address_i[31:s_offset], {s_offset{1'b0}}};
      if ((state == IDLE) && bus.write_i)
        wline <= bus.line_i;
      if (beat)
        cnt <= cnt + cnt_w'(1);
      if (beat && (state == READ))
        fill[cnt] <= bus.burst_i;
    end
  end

  assign bus.line_o    = fill;
  assign bus.burst_o   = wline[cnt];
  assign bus.address_o = addr;
  assign bus.read_o    = (state == READ);
  assign bus.write_o   = (state == WRITE);
  assign bus.resp_o    = (state == DONE);

endmodule
